counter_mod: RTL and testbench
==============================

# counter_mod

Parametrised modulo counter for timers, timeouts and rate generators. It generalises the fixed free-running counter with:
- configurable width and modulus;
- up/down direction, synchronous clear and parallel load;
- a built-in prescaler, a wrap or saturate terminal mode, and a registered terminal-event pulse.

## Interface

Parameters:
- WIDTH, 32, counter width in bits (2..32).
- MAX_VALUE, 10000, terminal value; count range is 0..MAX_VALUE; must satisfy 0 < MAX_VALUE < 2**WIDTH.
- PRESCALE, 1, number of enabled cycles per count step (1..65535); 1 means step on every enabled cycle.
- SATURATE, 0, terminal mode: 0 = wrap, 1 = saturate at the end of range.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low (rst_n); asserting it forces all state to reset values immediately; release is synchronised externally.
- clear  input  1  synchronous clear of count and prescaler.
- en  input  1  count enable; prescaler advances only while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value for load.
- q  output  WIDTH  current count (registered).
- wrap  output  1  one-cycle registered pulse on a wrap event (wrap mode only).
- at_max  output  1  q == MAX_VALUE (combinational from q).
- at_zero  output  1  q == 0 (combinational from q).

## Operation

- State: count register q, prescaler register psc (width ceil(log2(PRESCALE)), min 1 bit), wrap register.
- Per-edge priority is clear > load > step > hold.
- **clear:** q <= 0, psc <= 0, wrap <= 0.
- **load:**
  - q <= min(load_value, MAX_VALUE); out-of-range values clamp to MAX_VALUE.
  - psc <= 0, wrap <= 0.
- **Step condition:** en && psc == PRESCALE-1.
  - On step, psc <= 0; otherwise, while en, psc <= psc+1.
  - When en is low, psc holds.
  - With PRESCALE = 1, the step condition is simply en.
- **Step, up = 1:**
  - q < MAX_VALUE: q <= q+1.
  - q == MAX_VALUE, wrap mode: q <= 0, wrap <= 1.
  - q == MAX_VALUE, saturate mode: q holds, wrap <= 0.
- **Step, up = 0:**
  - q > 0: q <= q-1.
  - q == 0, wrap mode: q <= MAX_VALUE, wrap <= 1.
  - q == 0, saturate mode: q holds.
- **wrap pulse:** any edge that is not a wrapping step drives wrap <= 0, so wrap is never high for more than one cycle per event.
- **Arithmetic:** at WIDTH bits. The compare-before-step rule guarantees no natural overflow, because q never leaves 0..MAX_VALUE.
- **Invalid parameters:** elaboration-time assertion on invalid parameters (MAX_VALUE out of range, PRESCALE = 0).

## Timing

- **Reset values:** q = 0, psc = 0, wrap = 0, at_zero = 1, at_max = 0. They hold asynchronously while rst_n = 0, including when reset asserts mid-count.
- **Latency:**
  - q reflects clear/load/step one edge after the inputs are sampled.
  - wrap is high during the cycle in which q first shows the wrapped value.
- **Step rate:** with en held high, q steps every PRESCALE cycles. The first step after reset, clear or load occurs on the PRESCALE-th enabled edge.
- **Direction changes:** a direction change between steps is legal and takes effect on the next step. psc is unaffected.
- **load with en:** load on the same edge as a would-be step wins. That step is lost and the prescaler restarts.
- **clear with load:** simultaneous clear and load gives q = 0.
- **Flags:** at_max and at_zero change in the same cycle as q. There is no glitch filtering; consumers register them if needed.

## Test plan

- Reset/wrap-up: WIDTH=8, MAX_VALUE=5, PRESCALE=1, en=1, up=1 after reset.
  - q sequence 0,1,2,3,4,5,0,1.
  - wrap high only in the cycle q returns to 0.
  - at_max high while q=5.
- Down wrap: MAX_VALUE=5, load 1, then en=1, up=0.
  - q: 1,0,5,4.
  - wrap pulses exactly once, in the cycle q=5.
- Saturate: SATURATE=1, MAX_VALUE=5.
  - Count up: q sticks at 5 for 10 more enabled cycles with wrap never high.
  - Then up=0: q goes to 4 on the next step.
- Prescaler: PRESCALE=3, MAX_VALUE=100, en=1.
  - q increments on enabled cycles 3, 6, 9.
  - Dropping en for 4 cycles mid-period delays the next step by exactly 4 cycles.
- Load/clear priority:
  - load_value=200 with MAX_VALUE=100 gives q=100.
  - load and clear on the same edge give q=0.
  - load on a step edge discards the step and restarts the prescaler (PRESCALE=3: next step 3 enabled cycles later).
- Async reset mid-operation: pull rst_n low between clock edges with q=42 and psc nonzero.
  - q=0 and wrap=0 immediately, without a clock edge.
  - After release, counting restarts from 0 with a full prescale period.

Source files
------------

// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - parametrised modulo counter with prescaler, wrap/saturate modes and terminal pulse
module counter_mod #(
  parameter int          WIDTH     = 32,
  parameter int unsigned MAX_VALUE = 10000,
  parameter int          PRESCALE  = 1,
  parameter int          SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  // Prescaler only needs to hold 0..PRESCALE-1; keep at least one bit so
  // PRESCALE=1 still has a legal (constant-zero) register.
  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE_Q    = WIDTH'(1);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
  localparam bit               SAT      = (SATURATE != 0);

  // Reject parameter sets that would let q leave its range or never step.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod: WIDTH must be within 2..32");
  end
  if (MAX_VALUE == 0 || 64'(MAX_VALUE) >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("counter_mod: MAX_VALUE must satisfy 0 < MAX_VALUE < 2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("counter_mod: PRESCALE must be within 1..65535");
  end

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_next;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             step;

  // A count step happens on the enabled cycle that completes a prescale period.
  assign step = en && (psc == PSC_LAST);

  // Next-state selection with priority clear > load > step > hold; q is
  // compared against its limits before stepping so it never leaves 0..MAX_VALUE.
  always_comb begin
    q_next    = q;
    psc_next  = psc;
    wrap_next = 1'b0;
    if (clear) begin
      q_next   = '0;
      psc_next = '0;
    end else if (load) begin
      q_next   = (load_value > MAX_Q) ? MAX_Q : load_value;
      psc_next = '0;
    end else if (step) begin
      psc_next = '0;
      if (up) begin
        if (q != MAX_Q) begin
          q_next = q + ONE_Q;
        end else if (!SAT) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (q != '0) begin
          q_next = q - ONE_Q;
        end else if (!SAT) begin
          q_next    = MAX_Q;
          wrap_next = 1'b1;
        end
      end
    end else if (en) begin
      psc_next = psc + PSC_ONE;
    end
  end

  // State registers; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      psc  <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      psc  <= psc_next;
      wrap <= wrap_next;
    end
  end

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// tb/tb_counter_mod.sv - self-checking bench for counter_mod against a behavioural model
module tb_counter_mod;

  localparam int W = 8;
  localparam int N = 3;
  // Instance 0: wrap, MAX 5, no prescale. Instance 1: wrap, MAX 100, PRESCALE 3.
  // Instance 2: saturate, MAX 5, no prescale.
  localparam int MAXV [N] = '{5, 100, 5};
  localparam int PS   [N] = '{1, 3, 1};
  localparam int SATV [N] = '{0, 0, 1};

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] q       [N];
  logic         wrap    [N];
  logic         at_max  [N];
  logic         at_zero [N];

  counter_mod #(.WIDTH(W), .MAX_VALUE(MAXV[0]), .PRESCALE(PS[0]), .SATURATE(SATV[0])) u_wrap5 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .up(up), .load(load),
    .load_value(load_value), .q(q[0]), .wrap(wrap[0]), .at_max(at_max[0]), .at_zero(at_zero[0]));

  counter_mod #(.WIDTH(W), .MAX_VALUE(MAXV[1]), .PRESCALE(PS[1]), .SATURATE(SATV[1])) u_psc3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .up(up), .load(load),
    .load_value(load_value), .q(q[1]), .wrap(wrap[1]), .at_max(at_max[1]), .at_zero(at_zero[1]));

  counter_mod #(.WIDTH(W), .MAX_VALUE(MAXV[2]), .PRESCALE(PS[2]), .SATURATE(SATV[2])) u_sat5 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .up(up), .load(load),
    .load_value(load_value), .q(q[2]), .wrap(wrap[2]), .at_max(at_max[2]), .at_zero(at_zero[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int mq  [N];
  int men [N];
  bit mw  [N];
  int total;
  int bad;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i]  = 0;
      men[i] = 0;
      mw[i]  = 1'b0;
    end
  endtask

  // Model: a count of enabled cycles since the last restart; every PS-th one is
  // a step, and the step is modular (wrap) or clamped (saturate) arithmetic.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clear) begin
          mq[i] = 0; men[i] = 0; mw[i] = 1'b0;
        end else if (load) begin
          mq[i]  = (int'(load_value) > MAXV[i]) ? MAXV[i] : int'(load_value);
          men[i] = 0;
          mw[i]  = 1'b0;
        end else begin
          mw[i] = 1'b0;
          if (en) begin
            men[i]++;
            if (men[i] == PS[i]) begin
              men[i] = 0;
              if (up) begin
                if (SATV[i] != 0) mq[i] = (mq[i] + 1 > MAXV[i]) ? MAXV[i] : mq[i] + 1;
                else begin
                  mw[i] = (mq[i] == MAXV[i]);
                  mq[i] = (mq[i] + 1) % (MAXV[i] + 1);
                end
              end else begin
                if (SATV[i] != 0) mq[i] = (mq[i] == 0) ? 0 : mq[i] - 1;
                else begin
                  mw[i] = (mq[i] == 0);
                  mq[i] = (mq[i] + MAXV[i]) % (MAXV[i] + 1);
                end
              end
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("q[%0d]", i), int'(q[i]), mq[i]);
      check($sformatf("wrap[%0d]", i), int'(wrap[i]), int'(mw[i]));
      check($sformatf("at_max[%0d]", i), int'(at_max[i]), int'(mq[i] == MAXV[i]));
      check($sformatf("at_zero[%0d]", i), int'(at_zero[i]), int'(mq[i] == 0));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit u);
    clear      = c;
    load       = l;
    load_value = W'(lv);
    en         = e;
    up         = u;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_q0", int'(q[0]), 0);
    check("rst_at_zero0", int'(at_zero[0]), 1);
    check("rst_at_max0", int'(at_max[0]), 0);
    check("rst_wrap0", int'(wrap[0]), 0);
    compare_all();
    cyc();
    cyc();
    rst_n = 1'b1;

    // Up count with wrap at 5
    drive(0, 0, 0, 1, 1);
    repeat (5) cyc();
    check("up_q0_at5", int'(q[0]), 5);
    check("up_at_max0", int'(at_max[0]), 1);
    check("up_q1_psc", int'(q[1]), 1);
    cyc();
    check("up_q0_wrapped", int'(q[0]), 0);
    check("up_wrap0_pulse", int'(wrap[0]), 1);
    check("up_q1_psc2", int'(q[1]), 2);
    check("up_q2_stuck", int'(q[2]), 5);
    check("up_wrap2_none", int'(wrap[2]), 0);
    cyc();
    check("up_q0_after", int'(q[0]), 1);
    check("up_wrap0_drop", int'(wrap[0]), 0);

    // Saturate: hold at 5, then step down
    repeat (10) cyc();
    check("sat_q2_hold", int'(q[2]), 5);
    drive(0, 0, 0, 1, 0);
    cyc();
    check("sat_q2_down", int'(q[2]), 4);

    // Down wrap from 1
    drive(0, 1, 1, 1, 0);
    cyc();
    check("dn_load_q0", int'(q[0]), 1);
    check("dn_load_q1", int'(q[1]), 1);
    drive(0, 0, 0, 1, 0);
    cyc();
    check("dn_q0_zero", int'(q[0]), 0);
    cyc();
    check("dn_q0_wrap", int'(q[0]), 5);
    check("dn_wrap0_pulse", int'(wrap[0]), 1);
    check("dn_q2_floor", int'(q[2]), 0);
    cyc();
    check("dn_q0_four", int'(q[0]), 4);
    check("dn_wrap0_drop", int'(wrap[0]), 0);
    check("dn_q1_psc", int'(q[1]), 0);

    // Prescaler with an en gap
    drive(1, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 1, 1);
    repeat (2) cyc();
    check("psc_q1_pre", int'(q[1]), 0);
    drive(0, 0, 0, 0, 1);
    repeat (4) cyc();
    check("psc_q1_gap", int'(q[1]), 0);
    drive(0, 0, 0, 1, 1);
    cyc();
    check("psc_q1_step", int'(q[1]), 1);
    repeat (2) cyc();
    check("psc_q1_wait", int'(q[1]), 1);
    cyc();
    check("psc_q1_step2", int'(q[1]), 2);

    // Load clamp and clear priority
    drive(0, 1, 200, 0, 1);
    cyc();
    check("ld_clamp_q1", int'(q[1]), 100);
    check("ld_clamp_q0", int'(q[0]), 5);
    drive(1, 1, 200, 1, 1);
    cyc();
    check("clr_ld_q1", int'(q[1]), 0);
    check("clr_ld_q0", int'(q[0]), 0);

    // Load on a would-be step edge restarts the prescaler
    drive(0, 0, 0, 1, 1);
    repeat (2) cyc();
    drive(0, 1, 10, 1, 1);
    cyc();
    check("ldstep_q1", int'(q[1]), 10);
    drive(0, 0, 0, 1, 1);
    repeat (2) cyc();
    check("ldstep_q1_hold", int'(q[1]), 10);
    cyc();
    check("ldstep_q1_next", int'(q[1]), 11);

    // Asynchronous reset mid-period
    drive(0, 1, 42, 0, 1);
    cyc();
    check("ar_q1_42", int'(q[1]), 42);
    drive(0, 0, 0, 1, 1);
    cyc();
    check("ar_q1_still42", int'(q[1]), 42);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_q1_now0", int'(q[1]), 0);
    check("ar_wrap1", int'(wrap[1]), 0);
    check("ar_at_zero1", int'(at_zero[1]), 1);
    compare_all();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("ar_q0_restart", int'(q[0]), 1);
    check("ar_q1_wait1", int'(q[1]), 0);
    cyc();
    check("ar_q1_wait2", int'(q[1]), 0);
    cyc();
    check("ar_q1_step", int'(q[1]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
